// File: rtl/plugboard_pkg.sv
// rtl/plugboard_pkg.sv - shared types and defaults for the plugboard pair table
package plugboard_pkg;

  localparam int LET_W_DEF = 5;
  localparam int ALPHA_DEF = 26;

  typedef enum logic [1:0] {
    OP_ADD    = 2'd0,
    OP_REMOVE = 2'd1,
    OP_CLEAR  = 2'd2,
    OP_NOP    = 2'd3
  } cfg_op_e;

  typedef enum logic [1:0] {
    ERR_OK            = 2'd0,
    ERR_BAD_LETTER    = 2'd1,
    ERR_CONFLICT      = 2'd2,
    ERR_FULL_NOTFOUND = 2'd3
  } cfg_err_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_RESP  = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/plugboard_pairs_if.sv
// rtl/plugboard_pairs_if.sv - command, substitution and status signals of the plugboard
interface plugboard_pairs_if
  import plugboard_pkg::*;
#(
  parameter int LET_W     = LET_W_DEF,
  parameter int NUM_PAIRS = 10
);
  localparam int CNT_W = $clog2(NUM_PAIRS + 1);

  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [1:0]           cfg_op;
  logic [LET_W-1:0]     cfg_a;
  logic [LET_W-1:0]     cfg_b;
  logic                 cfg_done;
  logic [1:0]           cfg_err;
  logic                 in_valid;
  logic [LET_W-1:0]     in_let;
  logic [LET_W-1:0]     in_letinv;
  logic                 out_valid;
  logic [LET_W-1:0]     out_let;
  logic [LET_W-1:0]     out_letinv;
  logic [NUM_PAIRS-1:0] active;
  logic [CNT_W-1:0]     pair_count;

  modport master (
    output cfg_valid, cfg_op, cfg_a, cfg_b, in_valid, in_let, in_letinv,
    input  cfg_ready, cfg_done, cfg_err, out_valid, out_let, out_letinv, active, pair_count
  );

  modport slave (
    input  cfg_valid, cfg_op, cfg_a, cfg_b, in_valid, in_let, in_letinv,
    output cfg_ready, cfg_done, cfg_err, out_valid, out_let, out_letinv, active, pair_count
  );

endinterface

// File: rtl/plug_lookup.sv
// rtl/plug_lookup.sv - maps one letter through the active pair slots
module plug_lookup
  import plugboard_pkg::*;
#(
  parameter int LET_W     = LET_W_DEF,
  parameter int ALPHA     = ALPHA_DEF,
  parameter int NUM_PAIRS = 10
) (
  input  logic [LET_W-1:0]                let_i,
  input  logic [NUM_PAIRS-1:0][LET_W-1:0] slot_a,
  input  logic [NUM_PAIRS-1:0][LET_W-1:0] slot_b,
  input  logic [NUM_PAIRS-1:0]            active,
  output logic [LET_W-1:0]                let_o,
  output logic [NUM_PAIRS-1:0]            match
);

  logic in_range;

  // The table never holds a letter twice, so at most one match bit is set.
  always_comb begin
    in_range = (int'(let_i) < ALPHA);
    match    = '0;
    let_o    = let_i;
    for (int i = 0; i < NUM_PAIRS; i++) begin
      match[i] = in_range && active[i] && ((slot_a[i] == let_i) || (slot_b[i] == let_i));
      if (match[i]) begin
        let_o = (slot_a[i] == let_i) ? slot_b[i] : slot_a[i];
      end
    end
  end

endmodule

// File: rtl/plugboard_pairs.sv
// rtl/plugboard_pairs.sv - reconfigurable Enigma plugboard with checked pair commands
module plugboard_pairs
  import plugboard_pkg::*;
#(
  parameter int LET_W     = LET_W_DEF,
  parameter int ALPHA     = ALPHA_DEF,
  parameter int NUM_PAIRS = 10
) (
  input logic           clk,
  input logic           rst_n,
  plugboard_pairs_if.slave bus
);

  localparam int CNT_W = $clog2(NUM_PAIRS + 1);

  cfg_state_e                     state_q, state_d;
  cfg_op_e                        op_q, op_d;
  logic [LET_W-1:0]               a_q, a_d, b_q, b_d;
  logic [NUM_PAIRS-1:0][LET_W-1:0] slot_a_q, slot_a_d, slot_b_q, slot_b_d;
  logic [NUM_PAIRS-1:0]           active_q, active_d;
  logic                           done_q, done_d;
  cfg_err_e                       err_q, err_d;
  logic                           out_valid_q, out_valid_d;
  logic [LET_W-1:0]               out_let_q, out_let_d, out_letinv_q, out_letinv_d;

  logic [LET_W-1:0]     fwd_let, inv_let, chk_a_let, chk_b_let;
  logic [NUM_PAIRS-1:0] fwd_match, inv_match, chk_a_match, chk_b_match;
  logic [NUM_PAIRS-1:0] free_oh;
  logic                 a_bad, b_bad;
  logic [CNT_W-1:0]     count;
  logic                 unused_sink;

  plug_lookup #(.LET_W(LET_W), .ALPHA(ALPHA), .NUM_PAIRS(NUM_PAIRS)) u_fwd (
    .let_i(bus.in_let), .slot_a(slot_a_q), .slot_b(slot_b_q), .active(active_q),
    .let_o(fwd_let), .match(fwd_match)
  );

  plug_lookup #(.LET_W(LET_W), .ALPHA(ALPHA), .NUM_PAIRS(NUM_PAIRS)) u_inv (
    .let_i(bus.in_letinv), .slot_a(slot_a_q), .slot_b(slot_b_q), .active(active_q),
    .let_o(inv_let), .match(inv_match)
  );

  // Command-side lookups only need the match vectors for conflict and removal search.
  plug_lookup #(.LET_W(LET_W), .ALPHA(ALPHA), .NUM_PAIRS(NUM_PAIRS)) u_chk_a (
    .let_i(a_q), .slot_a(slot_a_q), .slot_b(slot_b_q), .active(active_q),
    .let_o(chk_a_let), .match(chk_a_match)
  );

  plug_lookup #(.LET_W(LET_W), .ALPHA(ALPHA), .NUM_PAIRS(NUM_PAIRS)) u_chk_b (
    .let_i(b_q), .slot_a(slot_a_q), .slot_b(slot_b_q), .active(active_q),
    .let_o(chk_b_let), .match(chk_b_match)
  );

  assign unused_sink = ^{chk_a_let, chk_b_let, fwd_match, inv_match};

  assign a_bad   = (int'(a_q) >= ALPHA);
  assign b_bad   = (int'(b_q) >= ALPHA);
  assign free_oh = ~active_q & (active_q + NUM_PAIRS'(1));

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_PAIRS; i++) begin
      count = count + {{(CNT_W-1){1'b0}}, active_q[i]};
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    slot_a_d     = slot_a_q;
    slot_b_d     = slot_b_q;
    active_d     = active_q;
    done_d       = 1'b0;
    err_d        = ERR_OK;
    out_valid_d  = bus.in_valid;
    out_let_d    = fwd_let;
    out_letinv_d = inv_let;

    case (state_q)
      ST_IDLE: begin
        if (bus.cfg_valid) begin
          state_d = ST_CHECK;
          op_d    = cfg_op_e'(bus.cfg_op);
          a_d     = bus.cfg_a;
          b_d     = bus.cfg_b;
        end
      end
      ST_CHECK: begin
        state_d = ST_RESP;
        done_d  = 1'b1;
        case (op_q)
          OP_ADD: begin
            if (a_bad || b_bad || (a_q == b_q)) begin
              err_d = ERR_BAD_LETTER;
            end else if (|chk_a_match || |chk_b_match) begin
              err_d = ERR_CONFLICT;
            end else if (&active_q) begin
              err_d = ERR_FULL_NOTFOUND;
            end else begin
              for (int i = 0; i < NUM_PAIRS; i++) begin
                if (free_oh[i]) begin
                  slot_a_d[i] = a_q;
                  slot_b_d[i] = b_q;
                end
              end
              active_d = active_q | free_oh;
            end
          end
          OP_REMOVE: begin
            if (a_bad) begin
              err_d = ERR_BAD_LETTER;
            end else if (|chk_a_match) begin
              active_d = active_q & ~chk_a_match;
            end else begin
              err_d = ERR_FULL_NOTFOUND;
            end
          end
          OP_CLEAR: active_d = '0;
          default: ;
        endcase
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_NOP;
      a_q          <= '0;
      b_q          <= '0;
      slot_a_q     <= '0;
      slot_b_q     <= '0;
      active_q     <= '0;
      done_q       <= 1'b0;
      err_q        <= ERR_OK;
      out_valid_q  <= 1'b0;
      out_let_q    <= '0;
      out_letinv_q <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      slot_a_q     <= slot_a_d;
      slot_b_q     <= slot_b_d;
      active_q     <= active_d;
      done_q       <= done_d;
      err_q        <= err_d;
      out_valid_q  <= out_valid_d;
      out_let_q    <= out_let_d;
      out_letinv_q <= out_letinv_d;
    end
  end

  assign bus.cfg_ready  = (state_q == ST_IDLE);
  assign bus.cfg_done   = done_q;
  assign bus.cfg_err    = err_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_let    = out_let_q;
  assign bus.out_letinv = out_letinv_q;
  assign bus.active     = active_q;
  assign bus.pair_count = count;

endmodule

// File: tb/tb_plugboard_pairs.sv
// tb/tb_plugboard_pairs.sv - randomized self-checking bench for plugboard_pairs
module tb_plugboard_pairs;
  localparam int LET_W = 5;
  localparam int ALPHA = 26;
  localparam int NP    = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  int m_a [NP];
  int m_b [NP];
  bit m_act [NP];

  plugboard_pairs_if #(.LET_W(LET_W), .NUM_PAIRS(NP)) bus ();

  plugboard_pairs #(.LET_W(LET_W), .ALPHA(ALPHA), .NUM_PAIRS(NP)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_map(input int l);
    if (l >= ALPHA) return l;
    for (int i = 0; i < NP; i++) begin
      if (m_act[i] && m_a[i] == l) return m_b[i];
      if (m_act[i] && m_b[i] == l) return m_a[i];
    end
    return l;
  endfunction

  function automatic int model_active();
    int v = 0;
    for (int i = 0; i < NP; i++) if (m_act[i]) v |= (1 << i);
    return v;
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < NP; i++) if (m_act[i]) c++;
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NP; i++) begin
      m_act[i] = 1'b0;
      m_a[i] = 0;
      m_b[i] = 0;
    end
  endtask

  task automatic model_cmd(input int op, input int a, input int b, output int err);
    int slot;
    bit found;
    err = 0;
    case (op)
      0: begin
        if (a >= ALPHA || b >= ALPHA || a == b) err = 1;
        else if (model_map(a) != a || model_map(b) != b) err = 2;
        else begin
          slot = -1;
          for (int i = 0; i < NP; i++) if (!m_act[i] && slot < 0) slot = i;
          if (slot < 0) err = 3;
          else begin
            m_a[slot] = a;
            m_b[slot] = b;
            m_act[slot] = 1'b1;
          end
        end
      end
      1: begin
        if (a >= ALPHA) err = 1;
        else begin
          found = 1'b0;
          for (int i = 0; i < NP; i++) begin
            if (m_act[i] && (m_a[i] == a || m_b[i] == a)) begin
              m_act[i] = 1'b0;
              found = 1'b1;
            end
          end
          if (!found) err = 3;
        end
      end
      2: for (int i = 0; i < NP; i++) m_act[i] = 1'b0;
      default: ;
    endcase
  endtask

  task automatic do_cmd(input int op, input int a, input int b);
    int exp_err;
    model_cmd(op, a, b, exp_err);
    check("ready_before", bus.cfg_ready, 1);
    bus.cfg_valid = 1'b1;
    bus.cfg_op = op[1:0];
    bus.cfg_a = a[LET_W-1:0];
    bus.cfg_b = b[LET_W-1:0];
    step();
    bus.cfg_valid = 1'b0;
    check("ready_check", bus.cfg_ready, 0);
    check("done_early", bus.cfg_done, 0);
    step();
    check("ready_resp", bus.cfg_ready, 0);
    check("done_pulse", bus.cfg_done, 1);
    check("cfg_err", bus.cfg_err, exp_err);
    check("active", bus.active, model_active());
    check("pair_count", bus.pair_count, model_count());
    step();
    check("done_clear", bus.cfg_done, 0);
    check("ready_after", bus.cfg_ready, 1);
  endtask

  task automatic lookup(input int l, input int li);
    bus.in_valid = 1'b1;
    bus.in_let = l[LET_W-1:0];
    bus.in_letinv = li[LET_W-1:0];
    step();
    bus.in_valid = 1'b0;
    check("out_valid", bus.out_valid, 1);
    check("out_let", bus.out_let, model_map(l));
    check("out_letinv", bus.out_letinv, model_map(li));
  endtask

  initial begin
    int e;
    bus.cfg_valid = 1'b0;
    bus.cfg_op = 2'd0;
    bus.cfg_a = '0;
    bus.cfg_b = '0;
    bus.in_valid = 1'b0;
    bus.in_let = '0;
    bus.in_letinv = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", bus.cfg_ready, 1);
    check("rst_done", bus.cfg_done, 0);
    check("rst_err", bus.cfg_err, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_let", bus.out_let, 0);
    check("rst_active", bus.active, 0);
    check("rst_count", bus.pair_count, 0);
    rst_n = 1'b1;
    step();

    do_cmd(0, 0, 25);
    lookup(0, 25);
    lookup(3, 3);
    do_cmd(0, 0, 4);
    do_cmd(0, 7, 7);
    do_cmd(0, 26, 1);
    for (int k = 0; k < 9; k++) do_cmd(0, 2 * k + 1, 2 * k + 2);
    check("full_count", bus.pair_count, NP);
    do_cmd(0, 19, 20);
    do_cmd(1, 6, 0);
    check("slot3_freed", bus.active[3], 0);
    do_cmd(0, 19, 20);
    check("slot3_reused", bus.active[3], 1);
    lookup(19, 20);
    do_cmd(1, 21, 0);
    do_cmd(1, 30, 0);
    do_cmd(3, 1, 2);
    do_cmd(2, 0, 0);
    for (int l = 0; l < 32; l++) lookup(l, 31 - l);

    // ADD(2,11) commits while letter 2 is continuously looked up.
    bus.in_valid = 1'b1;
    bus.in_let = 5'd2;
    bus.in_letinv = 5'd11;
    bus.cfg_valid = 1'b1;
    bus.cfg_op = 2'd0;
    bus.cfg_a = 5'd2;
    bus.cfg_b = 5'd11;
    step();
    bus.cfg_valid = 1'b0;
    step();
    check("commit_done", bus.cfg_done, 1);
    check("commit_edge_let", bus.out_let, 2);
    check("commit_edge_inv", bus.out_letinv, 11);
    model_cmd(0, 2, 11, e);
    step();
    check("post_commit_let", bus.out_let, 11);
    check("post_commit_inv", bus.out_letinv, 2);
    bus.in_valid = 1'b0;
    step();

    for (int n = 0; n < 250; n++) begin
      int op;
      op = int'($urandom_range(0, 9));
      op = (op < 6) ? 0 : (op < 8) ? 1 : (op == 8) ? 3 : (($urandom_range(0, 3) == 0) ? 2 : 0);
      do_cmd(op, int'($urandom_range(0, 27)), int'($urandom_range(0, 27)));
      lookup(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      lookup(int'($urandom_range(0, 25)), int'($urandom_range(0, 25)));
    end

    // Asynchronous reset in the middle of a command.
    do_cmd(2, 0, 0);
    do_cmd(0, 1, 2);
    bus.in_valid = 1'b1;
    bus.cfg_valid = 1'b1;
    bus.cfg_op = 2'd0;
    bus.cfg_a = 5'd5;
    bus.cfg_b = 5'd6;
    step();
    bus.cfg_valid = 1'b0;
    check("pre_rst_out_valid", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    check("arst_done", bus.cfg_done, 0);
    check("arst_active", bus.active, 0);
    check("arst_count", bus.pair_count, 0);
    check("arst_out_valid", bus.out_valid, 0);
    bus.in_valid = 1'b0;
    step();
    check("arst_hold_done", bus.cfg_done, 0);
    rst_n = 1'b1;
    step();
    check("arst_ready", bus.cfg_ready, 1);
    check("arst_no_done", bus.cfg_done, 0);
    lookup(5, 1);
    lookup(2, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
